// File: rtl/vram_access_arbiter_pkg.sv
// Shared types and constants for the VRAM access arbiter.
package vram_access_arbiter_pkg;

    typedef enum logic [1:0] {HBLANK, VBLANK, OAM_SCAN, DRAWING} ppu_mode_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_PPU, OWN_DMA, OWN_CPU} owner_t;
    typedef enum logic [1:0] {IDLE, WAIT, INFLT, DONE} cpu_state_t;

    localparam logic [7:0] BLOCKED_RDATA = 8'hFF;

endpackage

// File: rtl/vram_access_arbiter_if.sv
// Requester, CPU and memory-macro signals of the VRAM arbiter in one bundle.
interface vram_access_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    import vram_access_arbiter_pkg::*;

    ppu_mode_t         ppu_mode;
    logic              ppu_req;
    logic [AW-1:0]     ppu_addr;
    logic              ppu_valid;
    logic [DW-1:0]     ppu_rdata;
    logic              dma_req;
    logic [AW-1:0]     dma_addr;
    logic              dma_valid;
    logic [DW-1:0]     dma_rdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [AW-1:0]     cpu_addr;
    logic [DW-1:0]     cpu_wdata;
    logic              cpu_ack;
    logic [DW-1:0]     cpu_rdata;
    logic              cpu_blocked;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  ppu_mode, ppu_req, ppu_addr, dma_req, dma_addr,
               cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output ppu_valid, ppu_rdata, dma_valid, dma_rdata,
               cpu_ack, cpu_rdata, cpu_blocked,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ppu_mode, ppu_req, ppu_addr, dma_req, dma_addr,
               cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  ppu_valid, ppu_rdata, dma_valid, dma_rdata,
               cpu_ack, cpu_rdata, cpu_blocked,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/vram_access_arbiter.sv
// Single-port VRAM arbiter: PPU > starved CPU > DMA > CPU, one access per cycle,
// read data routed back to its owner one cycle after the grant.
module vram_access_arbiter
    import vram_access_arbiter_pkg::*;
#(
    parameter int AW           = 13,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 16,
    parameter bit LOCK_MODE3   = 1'b1
) (
    input logic               clk,
    input logic               reset,
    vram_access_arbiter_if.slave bus
);
    // state      | meaning
    // IDLE       | no CPU transaction
    // WAIT       | CPU request arbitrating (or about to be blocked)
    // INFLT      | CPU access issued, ack/data this cycle
    // DONE       | acked, waiting for cpu_req to drop

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    cpu_state_t    cpu_state;
    owner_t        owner;
    owner_t        grant;
    logic [SW-1:0] starve;
    logic          cpu_wr_q;
    logic          cpu_blk_q;
    logic          cpu_locked;
    logic          cpu_elig;
    logic          cpu_forced;

    always_comb begin
        cpu_locked = LOCK_MODE3 && (bus.ppu_mode == DRAWING);
        cpu_elig   = (cpu_state == WAIT) && !cpu_locked;
        cpu_forced = cpu_elig && (starve == SW'(STARVE_LIMIT));
        grant      = OWN_NONE;
        if (reset)            grant = OWN_NONE;
        else if (bus.ppu_req) grant = OWN_PPU;
        else if (cpu_forced)  grant = OWN_CPU;
        else if (bus.dma_req) grant = OWN_DMA;
        else if (cpu_elig)    grant = OWN_CPU;
    end

    always_comb begin
        bus.mem_en    = (grant != OWN_NONE);
        bus.mem_we    = (grant == OWN_CPU) && bus.cpu_we;
        bus.mem_wdata = ((grant == OWN_CPU) && bus.cpu_we) ? bus.cpu_wdata : '0;
        case (grant)
            OWN_PPU: bus.mem_addr = bus.ppu_addr;
            OWN_DMA: bus.mem_addr = bus.dma_addr;
            OWN_CPU: bus.mem_addr = bus.cpu_addr;
            default: bus.mem_addr = '0;
        endcase
    end

    // Read data comes straight from the macro in the cycle after the grant.
    always_comb begin
        bus.ppu_valid   = (owner == OWN_PPU);
        bus.ppu_rdata   = (owner == OWN_PPU) ? bus.mem_rdata : '0;
        bus.dma_valid   = (owner == OWN_DMA);
        bus.dma_rdata   = (owner == OWN_DMA) ? bus.mem_rdata : '0;
        bus.cpu_ack     = (owner == OWN_CPU) || cpu_blk_q;
        bus.cpu_blocked = cpu_blk_q;
        if (cpu_blk_q)
            bus.cpu_rdata = DW'(BLOCKED_RDATA);
        else if ((owner == OWN_CPU) && !cpu_wr_q)
            bus.cpu_rdata = bus.mem_rdata;
        else
            bus.cpu_rdata = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_state <= IDLE;
            owner     <= OWN_NONE;
            starve    <= '0;
            cpu_wr_q  <= 1'b0;
            cpu_blk_q <= 1'b0;
        end else begin
            owner     <= grant;
            cpu_wr_q  <= (grant == OWN_CPU) && bus.cpu_we;
            cpu_blk_q <= 1'b0;
            if (grant == OWN_CPU)
                starve <= '0;
            else if (cpu_elig && (grant == OWN_DMA) && (starve != SW'(STARVE_LIMIT)))
                starve <= starve + SW'(1);
            case (cpu_state)
                IDLE:  if (bus.cpu_req) cpu_state <= WAIT;
                WAIT: begin
                    if (grant == OWN_CPU) begin
                        cpu_state <= INFLT;
                    end else if (cpu_locked) begin
                        cpu_blk_q <= 1'b1;
                        cpu_state <= DONE;
                    end
                end
                INFLT: cpu_state <= DONE;
                DONE:  if (!bus.cpu_req) cpu_state <= IDLE;
                default: cpu_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Bench for vram_access_arbiter: per-cycle reference model predicts grants and
// queues expected responses; a monitor pops and compares them as they appear.
`timescale 1ns/1ps
module tb_vram_access_arbiter;
    import vram_access_arbiter_pkg::*;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int LIMIT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    vram_access_arbiter_if #(.AW(AW), .DW(DW)) bus();

    vram_access_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT), .LOCK_MODE3(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         blk;
    } exp_t;

    exp_t ppu_q[$];
    exp_t dma_q[$];
    exp_t cpu_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [7:0] init_pat(input logic [12:0] a);
        return a[7:0] ^ {a[12:8], 3'b101};
    endfunction

    // VRAM macro: 1-cycle read latency; unwritten bytes read the init pattern
    logic [7:0] vram [0:8191];
    bit         vram_wr [0:8191];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                vram[bus.mem_addr]    <= bus.mem_wdata;
                vram_wr[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= vram_wr[bus.mem_addr] ? vram[bus.mem_addr] : init_pat(bus.mem_addr);
            end
        end
    end

    logic [7:0] ref_mem [logic [12:0]];
    function automatic logic [7:0] rd_ref(input logic [12:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
    endfunction

    function automatic exp_t mk(input int due, input logic [7:0] d, input bit blk);
        exp_t e;
        e.due = due; e.data = d; e.blk = blk;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // CPU requester and model of the CPU port
    bit          ag_req = 0;
    bit          ag_we = 0;
    logic [12:0] ag_addr = '0;
    logic [7:0]  ag_wdata = '0;
    int          ag_hold = 0;
    int          ag_ack_cyc = -1;
    bit          m_contend = 0;
    bit          m_finishing = 0;
    int          m_lost = 0;

    task automatic cpu_start(input bit we, input logic [12:0] a, input logic [7:0] d, input int hold);
        ag_req = 1; ag_we = we; ag_addr = a; ag_wdata = d; ag_hold = hold; ag_ack_cyc = -1;
    endtask

    task automatic step(input bit p_req, input logic [12:0] p_addr,
                        input bit d_req, input logic [12:0] d_addr, input logic [1:0] mode);
        int          cyc;
        int          win;
        bit          ok;
        bit          blk;
        logic [12:0] ea;
        @(negedge clk);
        cyc = edge_cnt + 1;
        if (ag_req && ag_ack_cyc >= 0 && cyc > ag_ack_cyc + ag_hold) begin
            ag_req = 0;
            ag_ack_cyc = -1;
        end
        bus.ppu_req = p_req;   bus.ppu_addr = p_addr;
        bus.dma_req = d_req;   bus.dma_addr = d_addr;
        bus.ppu_mode = ppu_mode_t'(mode);
        bus.cpu_req = ag_req;  bus.cpu_we = ag_we;
        bus.cpu_addr = ag_addr; bus.cpu_wdata = ag_wdata;
        #1;
        ok  = m_contend && (mode != 2'd3);
        blk = m_contend && (mode == 2'd3);
        if (p_req)                      win = 1;
        else if (ok && m_lost >= LIMIT) win = 3;
        else if (d_req)                 win = 2;
        else if (ok)                    win = 3;
        else                            win = 0;
        ea = (win == 1) ? p_addr : (win == 2) ? d_addr : ag_addr;
        chk("mem_en", bus.mem_en, win != 0);
        chk("mem_we", bus.mem_we, (win == 3) && ag_we);
        if (win != 0) chk("mem_addr", bus.mem_addr, ea);
        if (win == 3 && ag_we) chk("mem_wdata", bus.mem_wdata, ag_wdata);
        case (win)
            1: ppu_q.push_back(mk(cyc, rd_ref(p_addr), 1'b0));
            2: dma_q.push_back(mk(cyc, rd_ref(d_addr), 1'b0));
            3: begin
                cpu_q.push_back(mk(cyc, ag_we ? 8'h00 : rd_ref(ag_addr), 1'b0));
                if (ag_we) ref_mem[ag_addr] = ag_wdata;
            end
            default: ;
        endcase
        if (ok && win == 2 && m_lost < LIMIT) m_lost++;
        if (win == 3) begin
            m_lost = 0; m_contend = 0; m_finishing = 1; ag_ack_cyc = cyc + 1;
        end else if (blk) begin
            cpu_q.push_back(mk(cyc, 8'hFF, 1'b1));
            m_contend = 0; m_finishing = 1; ag_ack_cyc = cyc + 1;
        end else if (m_finishing) begin
            if (!ag_req) m_finishing = 0;
        end else if (!m_contend && ag_req) begin
            m_contend = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 13'h0, 1'b0, 13'h0, 2'd0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ppu_valid"}, bus.ppu_valid, 0);
        chk({tag, "_ppu_rdata"}, bus.ppu_rdata, 0);
        chk({tag, "_dma_valid"}, bus.dma_valid, 0);
        chk({tag, "_dma_rdata"}, bus.dma_rdata, 0);
        chk({tag, "_cpu_ack"}, bus.cpu_ack, 0);
        chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
        chk({tag, "_cpu_blocked"}, bus.cpu_blocked, 0);
        chk({tag, "_mem_en"}, bus.mem_en, 0);
    endtask

    task automatic mid_reset();
        step(1'b0, 13'h0, 1'b1, 13'h0ABC, 2'd0);
        @(posedge clk); #1;
        reset = 1;
        ppu_q.delete(); dma_q.delete(); cpu_q.delete();
        m_contend = 0; m_finishing = 0; m_lost = 0; ag_req = 0; ag_ack_cyc = -1;
        bus.ppu_req = 0; bus.dma_req = 0; bus.cpu_req = 0;
        @(negedge clk);
        check_quiet("midrst");
        @(negedge clk);
        reset = 0;
        idle(3);
    endtask

    // Monitor: compares every response the DUT presents against the queues
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #2;
            if (reset) continue;
            if (bus.ppu_valid) begin
                if (ppu_q.size() == 0) chk("ppu_unexpected_valid", bus.ppu_valid, 0);
                else begin
                    e = ppu_q.pop_front();
                    chk("ppu_cycle", edge_cnt, e.due);
                    chk("ppu_rdata", bus.ppu_rdata, e.data);
                end
            end else if (ppu_q.size() > 0 && ppu_q[0].due <= edge_cnt) begin
                chk("ppu_valid", bus.ppu_valid, 1);
                e = ppu_q.pop_front();
            end
            if (bus.dma_valid) begin
                if (dma_q.size() == 0) chk("dma_unexpected_valid", bus.dma_valid, 0);
                else begin
                    e = dma_q.pop_front();
                    chk("dma_cycle", edge_cnt, e.due);
                    chk("dma_rdata", bus.dma_rdata, e.data);
                end
            end else if (dma_q.size() > 0 && dma_q[0].due <= edge_cnt) begin
                chk("dma_valid", bus.dma_valid, 1);
                e = dma_q.pop_front();
            end
            if (bus.cpu_ack) begin
                if (cpu_q.size() == 0) chk("cpu_unexpected_ack", bus.cpu_ack, 0);
                else begin
                    e = cpu_q.pop_front();
                    chk("cpu_ack_cycle", edge_cnt, e.due);
                    chk("cpu_rdata", bus.cpu_rdata, e.data);
                    chk("cpu_blocked", bus.cpu_blocked, e.blk);
                end
            end else if (cpu_q.size() > 0 && cpu_q[0].due <= edge_cnt) begin
                chk("cpu_ack", bus.cpu_ack, 1);
                e = cpu_q.pop_front();
            end
        end
    end

    initial begin : driver
        int          ppu_pct;
        int          dma_pct;
        logic [1:0]  mode;
        bus.ppu_mode = HBLANK;
        bus.ppu_req = 0; bus.ppu_addr = '0;
        bus.dma_req = 0; bus.dma_addr = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        reset = 0;
        idle(2);

        // write then read back in HBLANK
        cpu_start(1'b1, 13'h1800, 8'h5A, 0);
        idle(4);
        cpu_start(1'b0, 13'h1800, 8'h00, 0);
        idle(5);

        // CPU read while drawing is blocked
        cpu_start(1'b0, 13'h0010, 8'h00, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 13'h0, 1'b0, 13'h0, 2'd3);
        idle(3);

        // all three requesting in OAM scan: PPU owns every cycle
        cpu_start(1'b0, 13'h1801, 8'h00, 0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 13'($urandom), 1'b1, 13'($urandom), 2'd2);
        idle(5);

        // DMA streaming starves the CPU until the forced slot
        cpu_start(1'b0, 13'h1800, 8'h00, 0);
        for (int i = 0; i < 22; i++) step(1'b0, 13'h0, 1'b1, 13'($urandom), 2'd0);
        idle(4);

        // write request held for ten cycles issues one write
        cpu_start(1'b1, 13'h1805, 8'hC3, 7);
        idle(14);
        cpu_start(1'b0, 13'h1805, 8'h00, 0);
        idle(5);

        mid_reset();
        cpu_start(1'b0, 13'h1805, 8'h00, 0);
        idle(5);

        // randomized traffic in regimes that favour different arbitration paths
        mode = 2'd0;
        ppu_pct = 25;
        dma_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                ppu_pct = ($urandom_range(0, 2) == 0) ? 0 : 10 * $urandom_range(0, 6);
                dma_pct = 30 + 10 * $urandom_range(0, 7);
            end
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if (!ag_req && $urandom_range(0, 3) == 0)
                cpu_start(1'($urandom_range(0, 1)), 13'h1800 + 13'($urandom_range(0, 15)),
                          8'($urandom), $urandom_range(0, 3));
            step(1'($urandom_range(0, 99) < ppu_pct), 13'($urandom),
                 1'($urandom_range(0, 99) < dma_pct), 13'($urandom), mode);
        end
        ag_hold = 0;
        idle(8);
        chk("ppu_q_drained", ppu_q.size(), 0);
        chk("dma_q_drained", dma_q.size(), 0);
        chk("cpu_q_drained", cpu_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
